// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a multi-cycle core.
// A load or store request seen in IDLE is captured, held for LATENCY wait
// cycles and answered with a one-cycle done strobe. The memory is accessed
// on the clock edge that enters RESP. Loads are sign- or zero-extended.
// Misaligned accesses, unsupported funct3 values and simultaneous
// read+write requests return err=1 with rdata=0 and leave memory unchanged.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   mem_read/write    - request levels from the core control unit
//   addr, wdata       - byte address and store data
//   funct3            - access size / sign selection
//   rdata             - load result, held until the next response
//   busy              - stall to the core (combinational)
//   done, err         - response strobe and fault flag (err valid with done)
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic            req;
  logic            from_in;
  logic            acc_rd, acc_wr;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_f3;
  logic [AW-1:0]   word_idx;
  logic [1:0]      off;
  logic            load_ok, store_ok, misaligned, acc_err;
  logic            access_go, wr_en;
  logic [3:0]      be;
  logic [31:0]     wr_word;
  logic [7:0]      rd_byte [4];
  logic [31:0]     rd_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;

  // Address bits above the storage index are deliberately ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign req = mem_read | mem_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter is loaded with LATENCY-1 so WAIT lasts
  // exactly LATENCY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; reset masks busy and done during the reset cycle itself.
  always_comb begin
    busy  = ~rst & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));
    done  = ~rst & (state_q == ST_RESP);
    err   = done & err_q;
    rdata = rdata_q;
  end

  // Request capture in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
    end else if (state_q == ST_IDLE && req) begin
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
      f3_q    <= funct3;
    end
  end

  // With LATENCY=0 the access happens on the capture edge, so the live
  // inputs are used directly instead of the captured copies.
  always_comb begin
    from_in   = (state_q == ST_IDLE);
    acc_rd    = from_in ? mem_read      : rd_q;
    acc_wr    = from_in ? mem_write     : wr_q;
    acc_addr  = from_in ? addr[AW+1:0]  : addr_q;
    acc_wdata = from_in ? wdata         : wdata_q;
    acc_f3    = from_in ? funct3        : f3_q;
    word_idx  = acc_addr[AW+1:2];
    off       = acc_addr[1:0];

    load_ok    = (acc_f3 == 3'b000) | (acc_f3 == 3'b001) | (acc_f3 == 3'b010) |
                 (acc_f3 == 3'b100) | (acc_f3 == 3'b101);
    store_ok   = (acc_f3 == 3'b000) | (acc_f3 == 3'b001) | (acc_f3 == 3'b010);
    misaligned = ((acc_f3[1:0] == 2'b01) & off[0]) |
                 ((acc_f3[1:0] == 2'b10) & (off != 2'b00));
    acc_err    = (acc_rd & acc_wr) | (acc_rd & ~load_ok) |
                 (acc_wr & ~store_ok) | misaligned;

    // Entering RESP marks the single access edge of a transaction.
    access_go = ~rst & (state_d == ST_RESP) & (state_q != ST_RESP);
    wr_en     = access_go & acc_wr & ~acc_err;

    be      = 4'b0000;
    wr_word = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        be      = 4'b0001 << off;
        wr_word = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // One byte-wide RAM per lane so partial stores need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) lane_mem[word_idx] <= wr_word[gi*8 +: 8];
      end
      assign rd_byte[gi] = lane_mem[word_idx];
    end
  endgenerate

  assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

  always_comb begin
    case (off)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase
  end

  // Response registers, loaded on the access edge and held until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (access_go) begin
      err_q   <= acc_err;
      rdata_q <= (acc_rd & ~acc_err) ? load_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // DUT with LATENCY=2
  logic        rd2, wr2;
  logic [31:0] addr2, wdata2;
  logic [2:0]  f32;
  logic [31:0] rdata2;
  logic        busy2, done2, err2;
  // DUT with LATENCY=0
  logic        rd0, wr0;
  logic [31:0] addr0, wdata0;
  logic [2:0]  f30;
  logic [31:0] rdata0;
  logic        busy0, done0, err0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t q2[$];
  exp_t q0[$];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut2 (
    .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2), .addr(addr2),
    .wdata(wdata2), .funct3(f32), .rdata(rdata2), .busy(busy2),
    .done(done2), .err(err2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(addr0),
    .wdata(wdata0), .funct3(f30), .rdata(rdata0), .busy(busy0),
    .done(done0), .err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the memory as an array of words, lanes handled by shifts.
  task automatic model(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       output logic [31:0] rv, output logic e);
    int          i;
    int          sh;
    logic [31:0] w, t;
    bit          mis;
    i   = int'(a[9:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[i];
    t   = w >> sh;
    mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    rv  = 32'd0;
    if (rd && wr)  e = 1'b1;
    else if (rd)   e = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || mis;
    else           e = !(f3 inside {3'd0, 3'd1, 3'd2}) || mis;
    if (!e && rd) begin
      case (f3)
        3'd0:    rv = 32'($signed(t[7:0]));
        3'd1:    rv = 32'($signed(t[15:0]));
        3'd2:    rv = w;
        3'd4:    rv = t & 32'hFF;
        default: rv = t & 32'hFFFF;
      endcase
    end
    if (!e && wr) begin
      case (f3)
        3'd0:    ref_mem[i] = (w & ~(32'hFF << sh))   | ((d & 32'hFF) << sh);
        3'd1:    ref_mem[i] = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        default: ref_mem[i] = d;
      endcase
    end
  endtask

  // One transaction on the LATENCY=2 DUT; inputs are scrambled during WAIT.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    exp_t e;
    @(negedge clk);
    rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d; f32 = f3;
    model(rd, wr, a, d, f3, e.rdata, e.err);
    e.chk_rdata = e.err || (rd && !wr);
    e.cyc = cyc + LAT + 1;
    q2.push_back(e);
    $display("[TB] req rd=%0b wr=%0b addr=%h wdata=%h f3=%0d -> exp err=%0b rdata=%h",
             rd, wr, a, d, f3, e.err, e.rdata);
    #1 chk("busy_on_request", 32'(busy2), 32'd1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      rd2 = 1'($urandom); wr2 = 1'($urandom); addr2 = $urandom;
      wdata2 = $urandom; f32 = 3'($urandom);
      #1 chk("busy_in_wait", 32'(busy2), 32'd1);
    end
    @(negedge clk);
    rd2 = 1'b0; wr2 = 1'b0;
    #1 chk("busy_in_resp", 32'(busy2), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done_lat2", 32'(done2), 32'd0);
      end else begin
        e = q2.pop_front();
        chk("done_cycle_lat2", cyc, e.cyc);
        chk("err_lat2", 32'(err2), 32'(e.err));
        if (e.chk_rdata) chk("rdata_lat2", rdata2, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("unexpected_done_lat0", 32'(done0), 32'd0);
      end else begin
        e = q0.pop_front();
        chk("done_cycle_lat0", cyc, e.cyc);
        chk("err_lat0", 32'(err0), 32'(e.err));
        if (e.chk_rdata) chk("rdata_lat0", rdata0, e.rdata);
      end
    end
  end

  initial begin
    logic [31:0] a, d, d0;
    logic [2:0]  f3;
    int          r;
    exp_t        e;

    rst = 1'b1;
    rd2 = 1'b1; wr2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0; f32 = 3'd2;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; f30 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rdata", rdata2, 32'd0);
    chk("reset_done", 32'(done2), 32'd0);
    chk("reset_err", 32'(err2), 32'd0);
    chk("reset_busy", 32'(busy2), 32'd0);
    chk("reset_busy_lat0", 32'(busy0), 32'd0);
    rd2 = 1'b0; rd0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Give the low words known contents
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(4 * i), $urandom, 3'd2);

    // Directed cases
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    issue(1'b0, 1'b1, 32'h11, 32'h80, 3'd0);
    issue(1'b1, 1'b0, 32'h11, 32'd0, 3'd0);
    issue(1'b1, 1'b0, 32'h11, 32'd0, 3'd4);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    chk("sb_merge_model", ref_mem[4], 32'hDEAD80EF);
    issue(1'b1, 1'b0, 32'h12, 32'd0, 3'd2);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    issue(1'b1, 1'b1, 32'h10, 32'h5555AAAA, 3'd2);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    issue(1'b0, 1'b1, 32'h400, 32'h12345678, 3'd2);
    issue(1'b1, 1'b0, 32'h0, 32'd0, 3'd2);

    // Reset during WAIT aborts a store to 0x20
    @(negedge clk);
    rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hCAFEF00D; f32 = 3'd2;
    $display("[TB] req SW addr=00000020 aborted by reset during WAIT");
    @(negedge clk);
    wr2 = 1'b0; rst = 1'b1;
    #1 chk("busy_during_reset", 32'(busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(1'b1, 1'b0, 32'h20, 32'd0, 3'd2);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      d = $urandom;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(4, 5));
      r = $urandom_range(0, 9);
      if (r == 0)      issue(1'b1, 1'b1, a, d, f3);
      else if (r < 5)  issue(1'b0, 1'b1, a, d, f3);
      else             issue(1'b1, 1'b0, a, d, f3);
    end

    // LATENCY=0: requests held high across RESP
    d0 = $urandom;
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b1; addr0 = 32'h8; wdata0 = d0; f30 = 3'd2;
    e.rdata = 32'd0; e.err = 1'b0; e.chk_rdata = 1'b0; e.cyc = cyc + 1;
    q0.push_back(e);
    $display("[TB] lat0 req SW addr=00000008 wdata=%h", d0);
    #1 chk("lat0_busy_idle", 32'(busy0), 32'd1);
    @(negedge clk);
    rd0 = 1'b1; wr0 = 1'b0; f30 = 3'd2;
    e.rdata = d0; e.err = 1'b0; e.chk_rdata = 1'b1; e.cyc = cyc + 2;
    q0.push_back(e);
    $display("[TB] lat0 req LW addr=00000008 held across RESP");
    #1 chk("lat0_busy_resp", 32'(busy0), 32'd0);
    @(negedge clk);
    #1 chk("lat0_busy_next_idle", 32'(busy0), 32'd1);
    @(negedge clk);
    rd0 = 1'b0;
    @(negedge clk);
    rd0 = 1'b1; addr0 = 32'h9; f30 = 3'd1;
    e.rdata = 32'd0; e.err = 1'b1; e.chk_rdata = 1'b1; e.cyc = cyc + 1;
    q0.push_back(e);
    $display("[TB] lat0 req LH addr=00000009 (misaligned)");
    @(negedge clk);
    rd0 = 1'b0;
    @(negedge clk);
    rd0 = 1'b1; addr0 = 32'hA; f30 = 3'd4;
    e.rdata = (d0 >> 16) & 32'hFF; e.err = 1'b0; e.chk_rdata = 1'b1; e.cyc = cyc + 1;
    q0.push_back(e);
    $display("[TB] lat0 req LBU addr=0000000a");
    @(negedge clk);
    rd0 = 1'b0;

    repeat (6) @(negedge clk);
    chk("pending_lat2", 32'(q2.size()), 32'd0);
    chk("pending_lat0", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
